mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 23 ++
 rtl/mem_arbiter_rr_next.sv | 30 +++
 rtl/mem_arbiter.sv | 101 ++++++++++
 tb/tb_mem_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared bus constants and types for the memory arbiter slice.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W = 17;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    // Per-cycle arbitration outcome for the current owner.
    typedef enum logic [1:0] {
        DEC_ROTATE = 2'd0,  // no hold requested: round-robin to next requester
        DEC_KEEP   = 2'd1,  // hold honoured: owner stays, counter advances
        DEC_EXPIRE = 2'd2,  // hold requested but budget used up: forced rotate
        DEC_DROP   = 2'd3   // owner stopped requesting: channel 0 takes the bus
    } arb_dec_e;

    // One channel's memory request beat.
    typedef struct packed {
        logic [BE_W-1:0]   be;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } mem_beat_t;

endpackage

// File: rtl/mem_arbiter_rr_next.sv
// Round-robin successor: first requesting channel after the owner, wrapping.
module rr_next
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned N_CH = 4,
    parameter int unsigned OW   = 2
) (
    input  logic [OW-1:0]   i_owner,
    input  logic [N_CH-1:0] i_req,
    output logic [OW-1:0]   o_next
);

    logic        w_found;
    int unsigned w_idx;

    // Search owner+1 .. owner+N_CH modulo N_CH; the last step lands on the owner itself.
    always_comb begin
        o_next  = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int unsigned k = 1; k <= N_CH; k++) begin
            w_idx = (32'(i_owner) + k) % N_CH;
            if (!w_found && (|(i_req & (N_CH'(1) << w_idx)))) begin
                w_found = 1'b1;
                o_next  = OW'(w_idx);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Memory arbiter: round-robin grant with bounded hold, channel 0 (CPU) as fallback.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_CH-1:0]          running,
    input  logic [N_CH-1:0]          hold,
    input  logic [BE_W*N_CH-1:0]     write_en,
    input  logic [ADDR_W*N_CH-1:0]   address,
    input  logic [DATA_W*N_CH-1:0]   data_in,
    output logic [N_CH-1:0]          active,
    output logic [BE_W-1:0]          mem_write_en,
    output logic [ADDR_W-1:0]        memory_address,
    output logic [DATA_W-1:0]        memory_data,
    output logic                     hold_expired
);

    localparam int unsigned OW = $clog2(N_CH);
    localparam int unsigned CW = $clog2(MAX_HOLD + 1);

    logic [OW-1:0]   r_owner;
    logic [CW-1:0]   r_cnt;

    logic [N_CH-1:0] w_run;
    logic [OW-1:0]   w_grant;
    logic [OW-1:0]   w_rr;
    logic [OW-1:0]   w_owner_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    arb_dec_e        w_dec;
    mem_beat_t       w_beat;

    // Channel 0 always counts as requesting.
    assign w_run = running | N_CH'(1);

    rr_next #(
        .N_CH (N_CH),
        .OW   (OW)
    ) u_rr_next (
        .i_owner (r_owner),
        .i_req   (w_run),
        .o_next  (w_rr)
    );

    // Grant the owner while it still requests, otherwise fall back to channel 0.
    always_comb begin
        w_grant = w_run[r_owner] ? r_owner : '0;
    end

    // Route the granted channel's request straight to memory.
    always_comb begin
        w_beat = '0;
        active = '0;
        active[w_grant] = 1'b1;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (w_grant == OW'(i)) begin
                w_beat.be   = write_en[i*BE_W +: BE_W];
                w_beat.addr = address[i*ADDR_W +: ADDR_W];
                w_beat.data = data_in[i*DATA_W +: DATA_W];
            end
        end
        mem_write_en   = w_beat.be;
        memory_address = w_beat.addr;
        memory_data    = w_beat.data;
    end

    // Classify this cycle and derive the next owner and hold counter.
    always_comb begin
        w_dec = DEC_ROTATE;
        if (!w_run[r_owner]) begin
            w_dec = DEC_DROP;
        end else if (hold[r_owner]) begin
            w_dec = (r_cnt < CW'(MAX_HOLD - 1)) ? DEC_KEEP : DEC_EXPIRE;
        end

        w_owner_nxt = w_rr;
        w_cnt_nxt   = '0;
        if (w_dec == DEC_KEEP) begin
            w_owner_nxt = r_owner;
            w_cnt_nxt   = r_cnt + CW'(1);
        end
    end

    // Expiry pulse is combinational with the forced rotation; reset masks it.
    assign hold_expired = reset && (w_dec == DEC_EXPIRE);

    // Owner and hold counter state; reset parks the bus on channel 0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_owner <= '0;
            r_cnt   <= '0;
        end else begin
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic.
module tb_mem_arbiter;

    localparam int N  = 4;
    localparam int MH = 8;

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    running, hold;
    logic [4*N-1:0]  write_en;
    logic [17*N-1:0] address;
    logic [32*N-1:0] data_in;
    logic [N-1:0]    active;
    logic [3:0]      mem_write_en;
    logic [16:0]     memory_address;
    logic [31:0]     memory_data;
    logic            hold_expired;

    mem_arbiter #(.N_CH(N), .MAX_HOLD(MH)) dut (
        .clock          (clock),
        .reset          (reset),
        .running        (running),
        .hold           (hold),
        .write_en       (write_en),
        .address        (address),
        .data_in        (data_in),
        .active         (active),
        .mem_write_en   (mem_write_en),
        .memory_address (memory_address),
        .memory_data    (memory_data),
        .hold_expired   (hold_expired)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model state: who owns the bus and how long it has been held.
    int m_owner = 0;
    int m_cnt   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_req(input int ch);
        return (ch == 0) || running[ch];
    endfunction

    function automatic int m_grant();
        return m_req(m_owner) ? m_owner : 0;
    endfunction

    function automatic bit m_expire();
        return m_req(m_owner) && hold[m_owner] && (m_cnt == MH - 1);
    endfunction

    // Apply one clock edge of the arbitration rules.
    task automatic model_step();
        if (m_req(m_owner) && hold[m_owner] && (m_cnt < MH - 1)) begin
            m_cnt++;
        end else begin
            int nxt = 0;
            m_cnt = 0;
            for (int k = N; k >= 1; k--)
                if (m_req((m_owner + k) % N)) nxt = (m_owner + k) % N;
            m_owner = nxt;
        end
    endtask

    task automatic check_outputs();
        int g = m_grant();
        chk("active",   64'(active),         64'(1 << g));
        chk("we",       64'(mem_write_en),   64'(write_en[g*4 +: 4]));
        chk("addr",     64'(memory_address), 64'(address[g*17 +: 17]));
        chk("data",     64'(memory_data),    64'(data_in[g*32 +: 32]));
        chk("expired",  64'(hold_expired),   64'(m_expire()));
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) begin
            write_en[i*4 +: 4]  = 4'($urandom);
            address[i*17 +: 17] = 17'($urandom);
            data_in[i*32 +: 32] = $urandom;
        end
    endtask

    // Check mid-cycle, then advance the model on the edge the DUT sees.
    task automatic cycle();
        @(negedge clock);
        check_outputs();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        m_owner = 0;
        m_cnt   = 0;
        chk("rst_active", 64'(active),         64'(1));
        chk("rst_addr",   64'(memory_address), 64'(address[16:0]));
        chk("rst_exp",    64'(hold_expired),   64'(0));
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] exp_rot [5];
        logic [N-1:0] exp_hact [10];
        bit           exp_hexp [10];
        exp_rot  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_hact = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
                     4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
        exp_hexp = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

        reset   = 1'b0;
        running = '0;
        hold    = '0;
        rand_data();
        #1;
        chk("reset_active", 64'(active), 64'(1));
        chk("reset_we",     64'(mem_write_en), 64'(write_en[3:0]));
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Only the CPU requests.
        running = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            rand_data();
            @(negedge clock);
            chk("cpu_only_active", 64'(active), 64'(1));
            chk("cpu_only_addr", 64'(memory_address), 64'(address[16:0]));
            #1;
            @(posedge clock);
            model_step();
            #1;
        end

        // All request, no hold: strict rotation from channel 0.
        running = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            rand_data();
            @(negedge clock);
            chk("rotate", 64'(active), 64'(exp_rot[c]));
            check_outputs();
            @(posedge clock);
            model_step();
            #1;
        end

        // Channels 0 and 2 only: 1 and 3 never granted.
        running = 4'b0101;
        for (int c = 0; c < 8; c++) begin
            rand_data();
            @(negedge clock);
            chk("alt_skip", 64'(active & 4'b1010), 64'(0));
            check_outputs();
            @(posedge clock);
            model_step();
            #1;
        end

        // Channel 1 holds continuously: 8 grants, expiry on the 8th, then CPU.
        pulse_reset();
        running = 4'b0011;
        hold    = 4'b0010;
        for (int c = 0; c < 10; c++) begin
            rand_data();
            @(negedge clock);
            chk("hold_active", 64'(active), 64'(exp_hact[c]));
            chk("hold_exp",    64'(hold_expired), 64'(exp_hexp[c]));
            check_outputs();
            @(posedge clock);
            model_step();
            #1;
        end

        // Channel 2 owns then drops its request mid-cycle.
        pulse_reset();
        running = 4'b0100;
        hold    = 4'b0100;
        rand_data();
        cycle();
        cycle();
        running = 4'b0000;
        write_en[11:8] = 4'b1111;
        write_en[3:0]  = 4'b0101;
        #1;
        chk("drop_active", 64'(active), 64'(1));
        chk("drop_we",     64'(mem_write_en), 64'(4'b0101));
        cycle();
        cycle();

        // Reset while channel 3 is mid-hold, then confirm a full fresh hold budget.
        running = 4'b1000;
        hold    = 4'b1000;
        for (int c = 0; c < 4; c++) begin
            rand_data();
            cycle();
        end
        chk("pre_rst_owner3", 64'(active), 64'(4'b1000));
        pulse_reset();
        for (int c = 0; c < 12; c++) begin
            rand_data();
            cycle();
        end

        // Randomized traffic with occasional mid-cycle resets.
        for (int c = 0; c < 400; c++) begin
            running = N'($urandom);
            hold    = N'($urandom) | N'($urandom);
            rand_data();
            if ($urandom_range(0, 60) == 0) pulse_reset();
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
